lr_class_scheduler: RTL and testbench
=====================================

# lr_class_scheduler

Time-multiplexes one shared 81-tap inner-product datapath (7-bit pixel window × theta bank, 32-bit result) across `NUM_CLASS` logistic-regression theta banks. For each window it issues the bank select, collects one score per class, and tracks the signed maximum. It returns the winning class index and score through a valid/ready result port. The block sits between the line buffer, which holds the 9×9 window, and the downstream classifier output logic.

## Interface
Parameters:
- `NUM_CLASS`, 10: number of theta banks/classes; legal range 2..16.
- `CLS_W`, 4: width of the class index; must satisfy 2^CLS_W ≥ NUM_CLASS.
- `ACC_W`, 32: width of the inner-product result.
- `CNT_W`, 16: width of the result counter.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `win_valid`, in, 1: line buffer presents a stable window; level signal.
- `win_ack`, out, 1: one-cycle pulse; all scores for the window are captured and the line buffer may advance.
- `ip_sel`, out, CLS_W: theta bank select driven to the shared datapath.
- `ip_hprime`, in, ACC_W: datapath result, two's-complement signed, combinational from window and `ip_sel`.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: downstream accepts the result.
- `res_class`, out, CLS_W: argmax class index.
- `res_score`, out, ACC_W: maximum score, signed.
- `busy`, out, 1: high in SCAN and OUT.
- `res_count`, out, CNT_W: number of completed result handshakes; wraps modulo 2^CNT_W.

## Operation
- FSM has three states: IDLE, SCAN and OUT. All outputs are registered.
- **IDLE**
  - `ip_sel`=0.
  - If `win_valid`=1: go to SCAN and clear the class counter k to 0.
- **SCAN** (k = 0..NUM_CLASS-1, one cycle per class)
  - `ip_sel`=k throughout the cycle; `ip_hprime` is sampled at the end of that cycle.
  - k=0: load best_score=ip_hprime and best_class=0 unconditionally.
  - k>0: replace best only if ip_hprime > best_score (signed compare). Ties keep the lower index.
  - k=NUM_CLASS-1: go to OUT, assert `win_ack` for exactly one cycle (the first OUT cycle), and return `ip_sel` to 0.
  - `win_valid` is not re-checked during SCAN. The line buffer must hold the window stable until `win_ack`.
- **OUT**
  - `res_valid`=1; `res_class`/`res_score` show best_class/best_score.
  - Result fields stay stable while `res_valid`=1 and `res_ready`=0.
  - On `res_valid`&`res_ready`: go to IDLE, drop `res_valid`, and increment `res_count`.
  - `win_valid` is ignored in OUT, including the `win_ack` cycle.
- `res_class`/`res_score` keep their last values after the handshake until the next OUT entry.
- Arithmetic: compare is full ACC_W signed, with no saturation. 0x8000_0000 is the most negative value and is a legal score.
- Reset (asynchronous, any state, including mid-SCAN or with a result pending):
  - State returns to IDLE; k=0.
  - `ip_sel`=0, `win_ack`=0, `res_valid`=0, `res_class`=0, `res_score`=0, `busy`=0, `res_count`=0.
  - Any partial result is discarded and no `win_ack` is issued for that window.

## Timing
- `win_valid` seen high in IDLE at cycle t → SCAN occupies cycles t+1..t+NUM_CLASS with `ip_sel`=0..NUM_CLASS-1.
- `win_ack` and `res_valid` both rise in cycle t+NUM_CLASS+1.
- With `res_ready` tied high: OUT lasts 1 cycle, IDLE at t+NUM_CLASS+2. Minimum window period is NUM_CLASS+2 cycles (12 at default).
- `res_count` updates on the clock edge that ends the handshake cycle.
- `busy` = (state≠IDLE), registered with the state.
- The datapath's combinational delay must close within one cycle from `ip_sel`.

## Test plan
1. **Reset values.** Assert `rst_n`=0 mid-SCAN (k=4) → all outputs 0 immediately. Then release, hold `win_valid`=0 → stays IDLE, no `win_ack`.
2. **Single window, distinct maximum.**
   - Stimulus: NUM_CLASS=10, scores {5,−3,17,2,9,0,16,−100,1,4}, `res_ready`=1, `win_valid` high at t.
   - Required: `ip_sel` steps 0..9 over t+1..t+10; `win_ack`=`res_valid`=1 at t+11 with `res_class`=2, `res_score`=17; `res_count`=1.
3. **Ties and negative scores.** All scores −7 → `res_class`=0, `res_score`=0xFFFF_FFF9. Scores {0x8000_0000, −1, −1, …} → `res_class`=1, `res_score`=−1.
4. **Backpressure.**
   - Stimulus: `res_ready`=0 for 20 cycles after OUT entry, `win_valid` held high throughout.
   - Required: `res_valid`/`res_class`/`res_score` stable; `win_ack` high exactly one cycle; no SCAN restart until the handshake plus one IDLE cycle.
5. **Back-to-back windows.** `win_valid` and `res_ready` held high for 3 windows → `win_ack` pulses every 12 cycles; `res_count` goes 1, 2, 3.
6. **Counter wrap.** CNT_W=4, run 17 result handshakes → `res_count` reads 1.

Source files
------------

// File: rtl/lr_class_scheduler.sv
// Shares one inner-product datapath across NUM_CLASS theta banks and reports the signed argmax. One cycle per class, so ack and result appear NUM_CLASS+1 cycles after the window.
// Backpressure: a stalled result holds the block in OUT. A new window is not accepted until the handshake completes and one IDLE cycle has passed.
module lr_class_scheduler #(
  parameter int NUM_CLASS = 10,
  parameter int CLS_W     = 4,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             win_valid,
  output logic             win_ack,
  output logic [CLS_W-1:0] ip_sel,
  input  logic [ACC_W-1:0] ip_hprime,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CLS_W-1:0] res_class,
  output logic [ACC_W-1:0] res_score,
  output logic             busy,
  output logic [CNT_W-1:0] res_count
);

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  localparam logic [CLS_W-1:0] LAST_K = CLS_W'(NUM_CLASS - 1);

  state_t                   state, state_nxt;
  logic [CLS_W-1:0]         k, k_nxt;
  logic signed [ACC_W-1:0]  best_score, cand_score;
  logic [CLS_W-1:0]         best_class, cand_class;
  logic                     last_k;

  assign last_k = (k == LAST_K);

  // Class 0 seeds the running max; later classes win only on a strict increase.
  always_comb begin
    cand_score = best_score;
    cand_class = best_class;
    if ((k == '0) || ($signed(ip_hprime) > best_score)) begin
      cand_score = $signed(ip_hprime);
      cand_class = k;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt = SCAN;
          k_nxt     = '0;
        end
      end
      SCAN: begin
        if (last_k) begin
          state_nxt = OUT;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      OUT: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_sel     <= '0;
      win_ack    <= 1'b0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      res_score  <= '0;
      busy       <= 1'b0;
      res_count  <= '0;
      best_score <= '0;
      best_class <= '0;
    end else begin
      ip_sel    <= (state_nxt == SCAN) ? k_nxt : '0;
      win_ack   <= (state == SCAN) && last_k;
      res_valid <= (state_nxt == OUT);
      busy      <= (state_nxt != IDLE);
      if (state == SCAN) begin
        best_score <= cand_score;
        best_class <= cand_class;
      end
      // Result fields are only reloaded on OUT entry, so they persist past the handshake.
      if ((state == SCAN) && last_k) begin
        res_class <= cand_class;
        res_score <= cand_score;
      end
      if ((state == OUT) && res_ready) begin
        res_count <= res_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lr_class_scheduler.sv
// Directed bench for lr_class_scheduler: a default instance plus a CNT_W=4 instance driven in lock-step.
module tb_lr_class_scheduler;

  localparam int NC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        win_valid;
  logic        res_ready;

  logic        win_ack,   win_ack4;
  logic [3:0]  ip_sel,    ip_sel4;
  logic [31:0] ip_hprime, ip_hprime4;
  logic        res_valid, res_valid4;
  logic [3:0]  res_class, res_class4;
  logic [31:0] res_score, res_score4;
  logic        busy,      busy4;
  logic [15:0] res_count;
  logic [3:0]  res_count4;

  logic [31:0] scores [16];
  logic [31:0] sc10   [10];

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  assign ip_hprime  = scores[ip_sel];
  assign ip_hprime4 = scores[ip_sel4];

  lr_class_scheduler dut (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_ack(win_ack),
    .ip_sel(ip_sel), .ip_hprime(ip_hprime), .res_valid(res_valid),
    .res_ready(res_ready), .res_class(res_class), .res_score(res_score),
    .busy(busy), .res_count(res_count)
  );

  lr_class_scheduler #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_ack(win_ack4),
    .ip_sel(ip_sel4), .ip_hprime(ip_hprime4), .res_valid(res_valid4),
    .res_ready(res_ready), .res_class(res_class4), .res_score(res_score4),
    .busy(busy4), .res_count(res_count4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic load_scores();
    for (int i = 0; i < 16; i++) scores[i] = (i < NC) ? sc10[i] : 32'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(win_ack),   32'h0);
    chk({tag, "_sel"},   32'(ip_sel),    32'h0);
    chk({tag, "_valid"}, 32'(res_valid), 32'h0);
    chk({tag, "_class"}, 32'(res_class), 32'h0);
    chk({tag, "_score"}, res_score,      32'h0);
    chk({tag, "_busy"},  32'(busy),      32'h0);
    chk({tag, "_cnt"},   32'(res_count), 32'h0);
    chk({tag, "_cnt4"},  32'(res_count4), 32'h0);
  endtask

  // Called on a falling edge with both instances idle; res_ready stays high.
  task automatic run_window(input string tag, input logic [3:0] ecls, input logic [31:0] escore);
    win_valid = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      chk({tag, "_sel"}, 32'(ip_sel), 32'(i));
    end
    @(negedge clk);
    chk({tag, "_ack"},   32'(win_ack),   32'h1);
    chk({tag, "_valid"}, 32'(res_valid), 32'h1);
    chk({tag, "_class"}, 32'(res_class), 32'(ecls));
    chk({tag, "_score"}, res_score,      escore);
    win_valid = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk({tag, "_ack_drop"},   32'(win_ack),    32'h0);
    chk({tag, "_valid_drop"}, 32'(res_valid),  32'h0);
    chk({tag, "_cnt"},        32'(res_count),  32'(exp_cnt % 65536));
    chk({tag, "_cnt4"},       32'(res_count4), 32'(exp_cnt % 16));
  endtask

  initial begin
    int nack;
    int base;

    rst_n     = 1'b0;
    win_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) scores[i] = 32'h0;

    repeat (2) @(negedge clk);
    chk_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-scan at k=4
    sc10 = '{32'd5, 32'hFFFF_FFFD, 32'd17, 32'd2, 32'd9, 32'd0, 32'd16, 32'hFFFF_FF9C, 32'd1, 32'd4};
    load_scores();
    win_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_sel", 32'(ip_sel), 32'd4);
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    win_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_ack",  32'(win_ack), 32'h0);
      chk("idle_sel",  32'(ip_sel), 32'h0);
    end

    // Distinct maximum at class 2
    run_window("w1", 4'd2, 32'd17);

    // All equal negative: lowest index wins
    for (int i = 0; i < NC; i++) sc10[i] = 32'hFFFF_FFF9;
    load_scores();
    run_window("tie", 4'd0, 32'hFFFF_FFF9);

    // Most negative value loses to -1
    sc10[0] = 32'h8000_0000;
    for (int i = 1; i < NC; i++) sc10[i] = 32'hFFFF_FFFF;
    load_scores();
    run_window("minneg", 4'd1, 32'hFFFF_FFFF);

    // Backpressure with win_valid held high
    for (int i = 0; i < NC; i++) sc10[i] = 32'(i * 3);
    sc10[6] = 32'd100;
    load_scores();
    win_valid = 1'b1;
    res_ready = 1'b0;
    repeat (NC) @(negedge clk);
    @(negedge clk);
    chk("bp_ack",   32'(win_ack),   32'h1);
    chk("bp_valid", 32'(res_valid), 32'h1);
    chk("bp_class", 32'(res_class), 32'd6);
    chk("bp_score", res_score,      32'd100);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_hold_ack",   32'(win_ack),   32'h0);
      chk("bp_hold_valid", 32'(res_valid), 32'h1);
      chk("bp_hold_class", 32'(res_class), 32'd6);
      chk("bp_hold_score", res_score,      32'd100);
      chk("bp_hold_busy",  32'(busy),      32'h1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("bp_hs_valid", 32'(res_valid), 32'h0);
    chk("bp_hs_busy",  32'(busy),      32'h0);
    chk("bp_hs_cnt",   32'(res_count), 32'(exp_cnt));
    chk("bp_keep_class", 32'(res_class), 32'd6);
    @(negedge clk);
    chk("bp_restart_busy", 32'(busy),   32'h1);
    chk("bp_restart_sel",  32'(ip_sel), 32'h0);
    win_valid = 1'b0;
    repeat (NC + 1) @(negedge clk);
    exp_cnt++;
    chk("bp_drain_busy", 32'(busy),      32'h0);
    chk("bp_drain_cnt",  32'(res_count), 32'(exp_cnt));

    // Three back-to-back windows
    base = exp_cnt;
    nack = 0;
    win_valid = 1'b1;
    res_ready = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (win_ack) begin
        nack++;
        chk("b2b_ack_cycle", 32'(c), 32'(12 * nack - 1));
      end
      if ((c % 12) == 0) chk("b2b_cnt", 32'(res_count), 32'(base + c / 12));
      if (c == 35) win_valid = 1'b0;
    end
    chk("b2b_nack", 32'(nack), 32'd3);
    exp_cnt += 3;

    // Counter wrap on the CNT_W=4 instance
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    sc10 = '{32'd5, 32'hFFFF_FFFD, 32'd17, 32'd2, 32'd9, 32'd0, 32'd16, 32'hFFFF_FF9C, 32'd1, 32'd4};
    load_scores();
    for (int n = 0; n < 17; n++) run_window("wrap", 4'd2, 32'd17);
    chk("wrap_cnt4", 32'(res_count4), 32'd1);
    chk("wrap_cnt16", 32'(res_count), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
